// File: rtl/hidden_state_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : hidden_state_writer_pkg
//  Brief   : Shared defaults, FSM encoding and helpers for the hidden-state writer.
//  Rev     : 1.0  initial release
// ============================================================================
package hidden_state_writer_pkg;

    localparam int c_DEF_DATA_WIDTH  = 16;
    localparam int c_DEF_READ_BURST  = 2;
    localparam int c_DEF_ADDR_WIDTH  = 8;
    localparam int c_DEF_HIDDEN_SIZE = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hidden_state_writer.sv
`default_nettype none
// ============================================================================
//  Module  : hidden_state_writer
//  Brief   : Packs a serial h_t element stream into READ_BURST-wide words and
//            writes one word per cycle into the hidden-state memory.
//  Rev     : 1.0  initial release
// ============================================================================
module hidden_state_writer
    import hidden_state_writer_pkg::*;
#(
    parameter int DATA_WIDTH  = c_DEF_DATA_WIDTH,
    parameter int READ_BURST  = c_DEF_READ_BURST,
    parameter int ADDR_WIDTH  = c_DEF_ADDR_WIDTH,
    parameter int HIDDEN_SIZE = c_DEF_HIDDEN_SIZE
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_start,
    input  logic                             i_in_valid,
    input  logic [DATA_WIDTH-1:0]            i_in_data,
    output logic                             o_in_ready,
    output logic                             o_wr_en,
    output logic [ADDR_WIDTH-2:0]            o_wr_addr,
    output logic [DATA_WIDTH*READ_BURST-1:0] o_wr_data,
    output logic                             o_busy,
    output logic                             o_vec_done
);

    localparam int NWORDS = ceil_div(HIDDEN_SIZE, READ_BURST);
    localparam int LANE_W = (READ_BURST > 1) ? $clog2(READ_BURST) : 1;
    localparam int ELEM_W = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1;
    localparam int WORD_W = ADDR_WIDTH - 1;
    localparam int PACK_W = DATA_WIDTH * READ_BURST;

    localparam logic [LANE_W-1:0] c_LAST_LANE = LANE_W'(READ_BURST - 1);
    localparam logic [ELEM_W-1:0] c_LAST_ELEM = ELEM_W'(HIDDEN_SIZE - 1);
    localparam logic [WORD_W-1:0] c_LAST_WORD = WORD_W'(NWORDS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [LANE_W-1:0]   r_lane_cnt;
    logic [ELEM_W-1:0]   r_elem_cnt;
    logic [WORD_W-1:0]   r_word_cnt;
    logic [PACK_W-1:0]   r_pack;
    logic [PACK_W-1:0]   w_pack_next;
    logic                r_wr_en;
    logic [WORD_W-1:0]   r_wr_addr;
    logic [PACK_W-1:0]   r_wr_data;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_clear;
    logic                w_last_elem;
    logic                w_word_done;

    assign w_last_elem = (r_elem_cnt == c_LAST_ELEM);
    assign w_word_done = (r_lane_cnt == c_LAST_LANE) || w_last_elem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_accept     = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_COLLECT;
                    w_clear      = 1'b1;
                end
            end
            ST_COLLECT: begin
                w_in_ready = 1'b1;
                w_accept   = i_in_valid;
                if (i_in_valid && w_last_elem) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Lane-indexed insert: the incoming element lands directly in its slot.
    always_comb begin
        w_pack_next = r_pack;
        for (int k = 0; k < READ_BURST; k++) begin
            if (r_lane_cnt == LANE_W'(k)) begin
                w_pack_next[k*DATA_WIDTH +: DATA_WIDTH] = i_in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane_cnt <= '0;
            r_elem_cnt <= '0;
            r_word_cnt <= '0;
            r_pack     <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_clear) begin
                r_lane_cnt <= '0;
                r_elem_cnt <= '0;
                r_word_cnt <= '0;
                r_pack     <= '0;
            end else if (w_accept) begin
                r_elem_cnt <= r_elem_cnt + 1'b1;
                if (w_word_done) begin
                    // Cleared pack register zero-fills the upper lanes of a short final word.
                    r_wr_en    <= 1'b1;
                    r_wr_addr  <= r_word_cnt;
                    r_wr_data  <= w_pack_next;
                    r_lane_cnt <= '0;
                    r_pack     <= '0;
                    if (r_word_cnt != c_LAST_WORD) begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                    end
                end else begin
                    r_pack     <= w_pack_next;
                    r_lane_cnt <= r_lane_cnt + 1'b1;
                end
            end
        end
    end

    assign o_in_ready = w_in_ready;
    assign o_wr_en    = r_wr_en;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_vec_done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_hidden_state_writer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_hidden_state_writer
//  Brief   : Directed self-checking bench for hidden_state_writer (HS=4, 3, 64).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_hidden_state_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        valid;
    logic [15:0] data;
    int          sel;

    logic        ready [3];
    logic        wr_en [3];
    logic        busy  [3];
    logic        done  [3];
    logic [6:0]  addr  [3];
    logic [31:0] wdata [3];

    always #5 clk = ~clk;

    hidden_state_writer #(.DATA_WIDTH(16), .READ_BURST(2), .ADDR_WIDTH(8), .HIDDEN_SIZE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .i_start(start && sel == 0), .i_in_valid(valid), .i_in_data(data),
        .o_in_ready(ready[0]), .o_wr_en(wr_en[0]), .o_wr_addr(addr[0]), .o_wr_data(wdata[0]),
        .o_busy(busy[0]), .o_vec_done(done[0]));

    hidden_state_writer #(.DATA_WIDTH(16), .READ_BURST(2), .ADDR_WIDTH(8), .HIDDEN_SIZE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .i_start(start && sel == 1), .i_in_valid(valid), .i_in_data(data),
        .o_in_ready(ready[1]), .o_wr_en(wr_en[1]), .o_wr_addr(addr[1]), .o_wr_data(wdata[1]),
        .o_busy(busy[1]), .o_vec_done(done[1]));

    hidden_state_writer #(.DATA_WIDTH(16), .READ_BURST(2), .ADDR_WIDTH(8), .HIDDEN_SIZE(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .i_start(start && sel == 2), .i_in_valid(valid), .i_in_data(data),
        .o_in_ready(ready[2]), .o_wr_en(wr_en[2]), .o_wr_addr(addr[2]), .o_wr_data(wdata[2]),
        .o_busy(busy[2]), .o_vec_done(done[2]));

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
        logic        done;
    } wr_t;

    wr_t got_q[$];
    wr_t exp_q[$];
    int  vd_cnt = 0;
    int  q_base;
    int  vd_base;
    int  n_chk  = 0;
    int  n_pass = 0;

    // Write monitor on the selected instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en[sel]) got_q.push_back({addr[sel], wdata[sel], done[sel]});
        if (done[sel])  vd_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic mark();
        q_base  = got_q.size();
        vd_base = vd_cnt;
        exp_q.delete();
    endtask

    task automatic compare(input string tag, input int exp_vd);
        int n;
        n = got_q.size() - q_base;
        check({tag, "_nwrites"}, 64'(n), 64'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), 64'(got_q[q_base + i]), 64'(exp_q[i]));
        check({tag, "_vec_done_cnt"}, 64'(vd_cnt - vd_base), 64'(exp_vd));
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input int max_gap);
        int  g;
        int  n;
        bit  acc;
        g = (max_gap > 0 && $urandom_range(1) == 1) ? int'($urandom_range(max_gap, 1)) : 0;
        valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
        valid = 1'b1;
        data  = d;
        acc   = 1'b0;
        n     = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = ready[sel];
            @(posedge clk); #1;
            n++;
        end
        if (!acc) check("accept_timeout", 64'(acc), 64'd1);
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [15:0] e [64];
        rst_n = 1'b0; start = 1'b0; valid = 1'b0; data = '0; sel = 0;
        idle(2);
        for (int i = 0; i < 3; i++)
            check($sformatf("reset_outs_%0d", i),
                  64'({ready[i], wr_en[i], busy[i], done[i], addr[i], wdata[i]}), 64'd0);
        rst_n = 1'b1;
        idle(1);

        // T1: HS=4 back-to-back
        sel = 0; mark();
        do_start();
        check("t1_busy_collect", 64'({busy[0], ready[0]}), 64'b11);
        for (int i = 1; i <= 4; i++) send(16'(i), 0);
        check("t1_done_state", 64'({busy[0], ready[0], done[0], wr_en[0]}), 64'b1011);
        idle(1);
        check("t1_idle_after", 64'({busy[0], done[0], wr_en[0]}), 64'b000);
        exp_q.push_back({7'd0, 32'h0002_0001, 1'b0});
        exp_q.push_back({7'd1, 32'h0004_0003, 1'b1});
        compare("t1", 1);

        // T2: HS=3, padded final word; element presented with start is not taken
        sel = 1; mark();
        start = 1'b1; valid = 1'b1; data = 16'hDEAD;
        idle(1);
        start = 1'b0;
        send(16'h1111, 0); send(16'h2222, 0); send(16'h3333, 0);
        idle(3);
        exp_q.push_back({7'd0, 32'h2222_1111, 1'b0});
        exp_q.push_back({7'd1, 32'h0000_3333, 1'b1});
        compare("t2", 1);

        // T3: HS=64, negative values, random gaps
        sel = 2; mark();
        for (int i = 0; i < 64; i++) e[i] = 16'(0 - (i * 37 + 1));
        do_start();
        for (int i = 0; i < 64; i++) send(e[i], 3);
        idle(4);
        for (int w = 0; w < 32; w++)
            exp_q.push_back({7'(w), e[2*w+1], e[2*w], (w == 31)});
        compare("t3", 1);

        // T4: start held while busy mid-vector
        sel = 0; mark();
        do_start();
        send(16'd1, 0); send(16'd2, 0);
        start = 1'b1;
        send(16'd3, 0);
        start = 1'b0;
        send(16'd4, 0);
        idle(3);
        exp_q.push_back({7'd0, 32'h0002_0001, 1'b0});
        exp_q.push_back({7'd1, 32'h0004_0003, 1'b1});
        compare("t4", 1);

        // T5: asynchronous reset after three accepts
        do_start();
        send(16'd1, 0); send(16'd2, 0); send(16'd3, 0);
        check("t5_busy_before", 64'({busy[0], ready[0]}), 64'b11);
        #2 rst_n = 1'b0;
        #1 check("t5_async_clear", 64'({ready[0], wr_en[0], busy[0], done[0], addr[0], wdata[0]}), 64'd0);
        #3 rst_n = 1'b1;
        idle(1);
        mark();
        do_start();
        send(16'd9, 0); send(16'd8, 0); send(16'd7, 0); send(16'd6, 0);
        idle(3);
        exp_q.push_back({7'd0, 32'h0008_0009, 1'b0});
        exp_q.push_back({7'd1, 32'h0006_0007, 1'b1});
        compare("t5", 1);

        // T6: two vectors, second start in the cycle after vec_done
        mark();
        do_start();
        for (int i = 1; i <= 4; i++) send(16'(i), 0);
        idle(1);
        do_start();
        for (int i = 5; i <= 8; i++) send(16'(i), 0);
        idle(3);
        exp_q.push_back({7'd0, 32'h0002_0001, 1'b0});
        exp_q.push_back({7'd1, 32'h0004_0003, 1'b1});
        exp_q.push_back({7'd0, 32'h0006_0005, 1'b0});
        exp_q.push_back({7'd1, 32'h0008_0007, 1'b1});
        compare("t6", 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
